// File: rtl/bit_serial_adder_seq.sv
// Bit-serial adder sequencer.
// Streams the latched operands LSB first through an external one-bit full-adder
// slice, one bit per clock. The ripple carry is kept in a local register and the
// result is assembled bit by bit. sum/cout are updated only when DONE is entered,
// so a previous result stays visible while the next addition is running.
module bit_serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic: operand capture, per-bit accumulation and FSM sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new request can be taken from DONE too, giving WIDTH+1 throughput.
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here: the addition in flight runs to completion.
        carry_d        = fa_cout;
        acc_d[cnt_q]   = fa_sum;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          sum_d   = acc_d;
          cout_d  = fa_cout;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Full-adder slice drive: the current operand bits and carry in RUN, quiet zeros otherwise.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == ST_RUN) begin
      fa_a = a_q[cnt_q];
      fa_b = b_q[cnt_q];
      if (cnt_q == CNT_ZERO) begin
        fa_cin = cin_q;
      end else begin
        fa_cin = carry_q;
      end
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  // State and datapath registers; an asynchronous reset aborts any addition in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      acc_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder_seq.sv
// Self-checking bench for bit_serial_adder_seq at WIDTH=8 (index 0) and WIDTH=16 (index 1).
// Each instance has a behavioural full-adder attached. An arithmetic model predicts every
// output on every cycle. Directed cases pin the model with hand-computed literals.
module tb_bit_serial_adder_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_w [2];
  logic [15:0] a_w     [2];
  logic [15:0] b_w     [2];
  logic        cin_w   [2];

  logic busy8, done8, cout8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
  logic [7:0] sum8;
  logic busy16, done16, cout16, fa_a16, fa_b16, fa_cin16, fa_sum16, fa_cout16;
  logic [15:0] sum16;

  assign fa_sum8   = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8  = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_sum16  = fa_a16 ^ fa_b16 ^ fa_cin16;
  assign fa_cout16 = (fa_a16 & fa_b16) | (fa_a16 & fa_cin16) | (fa_b16 & fa_cin16);

  bit_serial_adder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start_w[0]), .a(a_w[0][7:0]), .b(b_w[0][7:0]),
    .cin(cin_w[0]), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8));

  bit_serial_adder_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start_w[1]), .a(a_w[1]), .b(b_w[1]),
    .cin(cin_w[1]), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .fa_a(fa_a16), .fa_b(fa_b16), .fa_cin(fa_cin16), .fa_sum(fa_sum16), .fa_cout(fa_cout16));

  logic        busy_w [2], done_w [2], cout_w [2], fa_a_w [2], fa_b_w [2], fa_cin_w [2];
  logic [15:0] sum_w  [2];

  // Gather both instances' outputs into index-addressable arrays.
  always_comb begin
    busy_w[0] = busy8;  done_w[0] = done8;  cout_w[0] = cout8;  sum_w[0] = {8'h00, sum8};
    fa_a_w[0] = fa_a8;  fa_b_w[0] = fa_b8;  fa_cin_w[0] = fa_cin8;
    busy_w[1] = busy16; done_w[1] = done16; cout_w[1] = cout16; sum_w[1] = sum16;
    fa_a_w[1] = fa_a16; fa_b_w[1] = fa_b16; fa_cin_w[1] = fa_cin16;
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Rising-edge counter used for latency and throughput measurements.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wd(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic longint mask(input int w);
    return (longint'(1) << w) - longint'(1);
  endfunction

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (width %0d) at cycle %0d: got 0x%0h, required 0x%0h",
               nm, wd(d), cyc, act, exp);
    end
  endtask

  // Reference model: phase -1 = idle, 0..W-1 = bit-serial step index, W = completion cycle.
  int     phase    [2] = '{-1, -1};
  longint ma       [2] = '{0, 0};
  longint mb       [2] = '{0, 0};
  longint mc       [2] = '{0, 0};
  longint exp_sum  [2] = '{0, 0};
  longint exp_cout [2] = '{0, 0};

  // Model update: accept requests when not mid-operation, publish (a+b+cin) at completion.
  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        phase[d]    <= -1;
        exp_sum[d]  <= 0;
        exp_cout[d] <= 0;
      end else if (phase[d] == -1 || phase[d] == wd(d)) begin
        if (start_w[d]) begin
          ma[d]    <= longint'(a_w[d]) & mask(wd(d));
          mb[d]    <= longint'(b_w[d]) & mask(wd(d));
          mc[d]    <= longint'(cin_w[d]);
          phase[d] <= 0;
        end else begin
          phase[d] <= -1;
        end
      end else begin
        if (phase[d] == wd(d) - 1) begin
          exp_sum[d]  <= (ma[d] + mb[d] + mc[d]) & mask(wd(d));
          exp_cout[d] <= ((ma[d] + mb[d] + mc[d]) >> wd(d)) & longint'(1);
        end
        phase[d] <= phase[d] + 1;
      end
    end
  end

  // Per-cycle compare of every output of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int     p;
      bit     run;
      longint e_cin;
      p   = phase[d];
      run = (p >= 0) && (p < wd(d));
      e_cin = 0;
      if (run) begin
        if (p == 0) e_cin = mc[d];
        else e_cin = (((ma[d] & mask(p)) + (mb[d] & mask(p)) + mc[d]) >> p) & longint'(1);
      end
      chk("busy",   d, longint'(busy_w[d]), run ? 1 : 0);
      chk("done",   d, longint'(done_w[d]), (p == wd(d)) ? 1 : 0);
      chk("sum",    d, longint'(sum_w[d]),  exp_sum[d]);
      chk("cout",   d, longint'(cout_w[d]), exp_cout[d]);
      chk("fa_a",   d, longint'(fa_a_w[d]), run ? ((ma[d] >> p) & longint'(1)) : 0);
      chk("fa_b",   d, longint'(fa_b_w[d]), run ? ((mb[d] >> p) & longint'(1)) : 0);
      chk("fa_cin", d, longint'(fa_cin_w[d]), e_cin);
    end
  end

  // Present operands with start high; returns just after the accepting edge.
  task automatic start_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, output int k);
    a_w[d] = av; b_w[d] = bv; cin_w[d] = cv; start_w[d] = 1'b1;
    @(posedge clk); #2;
    k = cyc;
    start_w[d] = 1'b0;
  endtask

  // Bounded wait for done; t is the edge count at which done was seen (-1 on timeout).
  task automatic wait_done(input int d, output int t);
    t = -1;
    for (int i = 0; i < 4 * wd(d) + 8; i++) begin
      @(negedge clk);
      if (done_w[d]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout (width %0d): done never rose, required a done pulse", wd(d));
    end
  endtask

  // One randomized operation, with operand churn and ignored start pulses while running.
  task automatic rand_op(input int d);
    logic [15:0] ra, rb;
    logic        rc;
    int          k, t, w, j;
    w  = wd(d);
    ra = 16'($urandom);
    rb = 16'($urandom);
    rc = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) ra = 16'hFFFF;
    if ($urandom_range(0, 9) == 0) rb = 16'h0000;
    start_op(d, ra, rb, rc, k);
    a_w[d] = 16'($urandom); b_w[d] = 16'($urandom); cin_w[d] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) begin
      j = $urandom_range(0, w - 3);
      repeat (j) @(posedge clk);
      #2 start_w[d] = 1'b1;
      @(posedge clk); #2 start_w[d] = 1'b0;
    end
    wait_done(d, t);
    if (t >= 0) begin
      chk("rand_latency", d, longint'(t - k), longint'(w));
      chk("rand_sum",  d, longint'(sum_w[d]),
          (longint'(ra & 16'(mask(w))) + longint'(rb & 16'(mask(w))) + longint'(rc)) & mask(w));
      chk("rand_cout", d, longint'(cout_w[d]),
          ((longint'(ra & 16'(mask(w))) + longint'(rb & 16'(mask(w))) + longint'(rc)) >> w) & 1);
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #2;
  endtask

  logic [7:0] b2b_a   [4] = '{8'h80, 8'h7F, 8'h33, 8'hFE};
  logic [7:0] b2b_b   [4] = '{8'h80, 8'h01, 8'h44, 8'hFF};
  logic       b2b_c   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] b2b_sum [4] = '{8'h00, 8'h81, 8'h78, 8'hFE};
  logic       b2b_co  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Main directed sequence followed by concurrent random traffic on both widths.
  initial begin
    int k, t, tprev, n_done;
    for (int d = 0; d < 2; d++) begin
      start_w[d] = 1'b0; a_w[d] = 16'h0000; b_w[d] = 16'h0000; cin_w[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 0, longint'(busy8), 0);
    chk("reset_sum",  0, longint'(sum8), 0);
    chk("reset_cout", 0, longint'(cout8), 0);
    reset_n = 1'b1;

    // 0xFF + 0x01 + 0, started on the first edge after reset release.
    start_op(0, 16'h00FF, 16'h0001, 1'b0, k);
    wait_done(0, t);
    chk("ff01_latency", 0, longint'(t - k), 8);
    chk("ff01_sum",  0, longint'(sum8), 8'h00);
    chk("ff01_cout", 0, longint'(cout8), 1);

    // 0xA5 + 0x5A + 1: initial carry must appear on fa_cin in the first step.
    repeat (2) @(posedge clk);
    #2;
    start_op(0, 16'h00A5, 16'h005A, 1'b1, k);
    chk("a55a_fa_cin0", 0, longint'(fa_cin8), 1);
    wait_done(0, t);
    chk("a55a_sum",  0, longint'(sum8), 8'h00);
    chk("a55a_cout", 0, longint'(cout8), 1);

    // 0x12 + 0x34 with a second start pulse in step 3 that must be ignored.
    start_op(0, 16'h0012, 16'h0034, 1'b0, k);
    repeat (3) @(posedge clk);
    #2 start_w[0] = 1'b1; a_w[0] = 16'h00FF; b_w[0] = 16'h00FF;
    @(posedge clk); #2 start_w[0] = 1'b0;
    n_done = 0;
    repeat (27) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    chk("ignore_done_count", 0, longint'(n_done), 1);
    chk("ignore_sum",  0, longint'(sum8), 8'h46);
    chk("ignore_cout", 0, longint'(cout8), 0);

    // Back-to-back: start held high, new operands presented in each completion cycle.
    #2;
    a_w[0] = {8'h00, b2b_a[0]}; b_w[0] = {8'h00, b2b_b[0]}; cin_w[0] = b2b_c[0];
    start_w[0] = 1'b1;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (i == 0) k = cyc;
      a_w[0] = 16'($urandom); b_w[0] = 16'($urandom); cin_w[0] = 1'($urandom_range(0, 1));
      wait_done(0, t);
      if (i == 0) chk("b2b_first_latency", 0, longint'(t - k), 8);
      else chk("b2b_interval", 0, longint'(t - tprev), 9);
      tprev = t;
      chk("b2b_sum",  0, longint'(sum8), longint'(b2b_sum[i]));
      chk("b2b_cout", 0, longint'(cout8), longint'(b2b_co[i]));
      if (i < 3) begin
        a_w[0] = {8'h00, b2b_a[i+1]}; b_w[0] = {8'h00, b2b_b[i+1]}; cin_w[0] = b2b_c[i+1];
      end else begin
        start_w[0] = 1'b0;
      end
    end

    // Reset asserted in step 4 of an addition: outputs clear at once and no done follows.
    repeat (2) @(posedge clk);
    #2;
    start_op(0, 16'h000F, 16'h00F0, 1'b1, k);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy",   0, longint'(busy8), 0);
    chk("abort_done",   0, longint'(done8), 0);
    chk("abort_sum",    0, longint'(sum8), 0);
    chk("abort_cout",   0, longint'(cout8), 0);
    chk("abort_fa_a",   0, longint'(fa_a8), 0);
    chk("abort_fa_b",   0, longint'(fa_b8), 0);
    chk("abort_fa_cin", 0, longint'(fa_cin8), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    chk("abort_no_done", 0, longint'(n_done), 0);
    #2;
    start_op(0, 16'h003C, 16'h000F, 1'b0, k);
    wait_done(0, t);
    chk("after_abort_sum",  0, longint'(sum8), 8'h4B);
    chk("after_abort_cout", 0, longint'(cout8), 0);

    // Random traffic on both widths in parallel.
    #2;
    fork
      begin
        for (int n = 0; n < 1000; n++) rand_op(0);
      end
      begin
        for (int n = 0; n < 1000; n++) rand_op(1);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
